// File: rtl/decryption_output_packer.sv
// Packs the decrypted character stream little-endian into 32-bit words and
// buffers them in a show-ahead FIFO drained by a valid/ready handshake.
module decryption_output_packer #(
   parameter int                    SYS_DWIDTH = 8,
   parameter int                    MST_DWIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [SYS_DWIDTH-1:0] END_CHAR   = 8'hFA
) (
   input  logic                          clk_sys,
   input  logic                          rst_n,
   input  logic [SYS_DWIDTH-1:0]         data_i,
   input  logic                          valid_i,
   output logic [MST_DWIDTH-1:0]         data_o,
   output logic [3:0]                    byte_en_o,
   output logic                          last_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          overflow_o
);

   localparam int LANES = 4;
   localparam int AW    = $clog2(FIFO_DEPTH);

   // ---------------------------------------------------------------- packer
   logic [1:0]            pend_cnt_reg;
   logic [MST_DWIDTH-1:0] acc_reg;
   logic [MST_DWIDTH-1:0] acc_merged;
   logic [3:0]            end_be;

   logic                  is_end;
   logic                  push;
   logic [MST_DWIDTH-1:0] push_data;
   logic [3:0]            push_be;
   logic                  push_last;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign acc_merged[gi*SYS_DWIDTH +: SYS_DWIDTH] =
            (pend_cnt_reg == 2'(gi)) ? data_i : acc_reg[gi*SYS_DWIDTH +: SYS_DWIDTH];
         // A terminator closes the word with only the already-filled lanes valid.
         assign end_be[gi] = (2'(gi) < pend_cnt_reg);
      end
   endgenerate

   always_comb begin
      is_end    = (data_i == END_CHAR);
      push      = 1'b0;
      push_data = '0;
      push_be   = 4'b0000;
      push_last = 1'b0;
      if (valid_i) begin
         if (is_end) begin
            push      = 1'b1;
            push_data = acc_reg;
            push_be   = end_be;
            push_last = 1'b1;
         end else if (pend_cnt_reg == 2'd3) begin
            push      = 1'b1;
            push_data = acc_merged;
            push_be   = 4'b1111;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         pend_cnt_reg <= 2'd0;
         acc_reg      <= '0;
      end else if (valid_i) begin
         if (push) begin
            pend_cnt_reg <= 2'd0;
            acc_reg      <= '0;
         end else begin
            pend_cnt_reg <= pend_cnt_reg + 2'd1;
            acc_reg      <= acc_merged;
         end
      end
   end

   // ------------------------------------------------------------------ FIFO
   logic [MST_DWIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [3:0]            mem_be   [FIFO_DEPTH];
   logic                  mem_last [FIFO_DEPTH];

   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic [AW:0] level;
   logic        full;
   logic        pop;
   logic        do_write;
   logic        overflow_reg;

   assign level    = wr_ptr_reg - rd_ptr_reg;
   assign full     = (level == (AW+1)'(FIFO_DEPTH));
   assign pop      = (level != '0) && ready_i;
   // A pop at full frees the slot the simultaneous push needs.
   assign do_write = push && (!full || pop);

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_be[i]   <= 4'b0000;
            mem_last[i] <= 1'b0;
         end
      end else begin
         if (do_write) begin
            mem_data[wr_ptr_reg[AW-1:0]] <= push_data;
            mem_be[wr_ptr_reg[AW-1:0]]   <= push_be;
            mem_last[wr_ptr_reg[AW-1:0]] <= push_last;
            wr_ptr_reg                   <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && !do_write) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign data_o     = mem_data[rd_ptr_reg[AW-1:0]];
   assign byte_en_o  = mem_be[rd_ptr_reg[AW-1:0]];
   assign last_o     = mem_last[rd_ptr_reg[AW-1:0]];
   assign valid_o    = (level != '0);
   assign level_o    = level;
   assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_decryption_output_packer.sv
// Directed and randomized bench for decryption_output_packer, checked every
// cycle against a queue-based model of the packing rules.
module tb_decryption_output_packer;

   logic        clk_sys = 1'b0;
   logic        rst_n   = 1'b0;
   logic [7:0]  data_i  = 8'h00;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [31:0] data_o;
   logic [3:0]  byte_en_o;
   logic        last_o;
   logic        valid_o;
   logic [2:0]  level_o;
   logic        overflow_o;

   int checks = 0;
   int errors = 0;

   decryption_output_packer #(
      .SYS_DWIDTH(8), .MST_DWIDTH(32), .FIFO_DEPTH(4), .END_CHAR(8'hFA)
   ) dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .data_i    (data_i),
      .valid_i   (valid_i),
      .data_o    (data_o),
      .byte_en_o (byte_en_o),
      .last_o    (last_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .level_o   (level_o),
      .overflow_o(overflow_o)
   );

   always #5 clk_sys = ~clk_sys;

   // ----------------------------------------------------------------- model
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  be;
      logic        last;
   } word_t;

   word_t    mq[$];
   logic [7:0] cur[$];
   bit       m_ovf  = 1'b0;
   bit       m_init = 1'b0;

   function automatic word_t build(bit last);
      word_t w;
      w.d    = '0;
      w.be   = '0;
      w.last = last;
      foreach (cur[k]) begin
         w.d  = w.d | (32'(cur[k]) << (8 * k));
         w.be = w.be | (4'b0001 << k);
      end
      return w;
   endfunction

   always @(posedge clk_sys) begin
      if (!rst_n) begin
         mq.delete();
         cur.delete();
         m_ovf  = 1'b0;
         m_init = 1'b1;
      end else begin
         bit    popped;
         bit    pushed;
         int    lvl;
         word_t w;
         lvl    = mq.size();
         popped = (lvl != 0) && ready_i;
         pushed = 1'b0;
         if (valid_i) begin
            if (data_i == 8'hFA) begin
               w = build(1'b1);
               cur.delete();
               pushed = 1'b1;
            end else begin
               cur.push_back(data_i);
               if (cur.size() == 4) begin
                  w = build(1'b0);
                  cur.delete();
                  pushed = 1'b1;
               end
            end
         end
         if (popped) void'(mq.pop_front());
         if (pushed) begin
            if (lvl < 4 || popped) mq.push_back(w);
            else m_ovf = 1'b1;
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_sys) begin
      if (m_init) begin
         check("valid_o", 32'(valid_o), 32'(mq.size() != 0));
         check("level_o", 32'(level_o), 32'(mq.size()));
         check("overflow_o", 32'(overflow_o), 32'(m_ovf));
         if (mq.size() != 0) begin
            check("data_o", data_o, mq[0].d);
            check("byte_en_o", 32'(byte_en_o), 32'(mq[0].be));
            check("last_o", 32'(last_o), 32'(mq[0].last));
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic cyc(bit v, logic [7:0] d, bit r);
      valid_i = v;
      data_i  = d;
      ready_i = r;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset(int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) cyc(1'b1, 8'h5A, 1'b1);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset(2);
      check("rst valid_o", 32'(valid_o), 32'd0);
      check("rst level_o", 32'(level_o), 32'd0);
      check("rst data_o", data_o, 32'd0);
      check("rst overflow_o", 32'(overflow_o), 32'd0);

      // Full word
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h41 + 8'(i), 1'b0);
      check("full data", data_o, 32'h44434241);
      check("full be", 32'(byte_en_o), 32'hF);
      check("full last", 32'(last_o), 32'd0);
      check("full level", 32'(level_o), 32'd1);

      // Partial word closed by terminator, then pop both
      cyc(1'b1, 8'h45, 1'b0);
      cyc(1'b1, 8'h46, 1'b0);
      cyc(1'b1, 8'hFA, 1'b0);
      check("partial level", 32'(level_o), 32'd2);
      cyc(1'b0, 8'h00, 1'b1);
      check("partial data", data_o, 32'h00004645);
      check("partial be", 32'(byte_en_o), 32'h3);
      check("partial last", 32'(last_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);
      check("drained valid", 32'(valid_o), 32'd0);

      // Lone terminator
      cyc(1'b1, 8'hFA, 1'b0);
      check("lone valid", 32'(valid_o), 32'd1);
      check("lone data", data_o, 32'd0);
      check("lone be", 32'(byte_en_o), 32'd0);
      check("lone last", 32'(last_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);

      // Overflow: five words into a four-deep FIFO
      for (int i = 0; i < 20; i++) cyc(1'b1, 8'h01 + 8'(i), 1'b0);
      check("ovf level", 32'(level_o), 32'd4);
      check("ovf flag", 32'(overflow_o), 32'd1);
      check("ovf head", data_o, 32'h04030201);
      cyc(1'b0, 8'h00, 1'b1);
      check("ovf word2", data_o, 32'h08070605);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
      check("ovf drained", 32'(valid_o), 32'd0);
      check("ovf sticky", 32'(overflow_o), 32'd1);

      // Simultaneous push and pop at full
      do_reset(1);
      for (int i = 0; i < 19; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
      cyc(1'b1, 8'h73, 1'b1);
      check("pp level", 32'(level_o), 32'd4);
      check("pp overflow", 32'(overflow_o), 32'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
      check("pp 5th word", data_o, 32'h73727170);
      cyc(1'b0, 8'h00, 1'b1);
      check("pp drained", 32'(valid_o), 32'd0);

      // Reset mid-word
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h22, 1'b0);
      rst_n = 1'b0;
      cyc(1'b1, 8'h33, 1'b0);
      check("midrst valid", 32'(valid_o), 32'd0);
      check("midrst data", data_o, 32'd0);
      check("midrst be", 32'(byte_en_o), 32'd0);
      check("midrst last", 32'(last_o), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h31 + 8'(i), 1'b0);
      check("midrst word", data_o, 32'h34333231);
      check("midrst be full", 32'(byte_en_o), 32'hF);
      check("midrst level", 32'(level_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);

      // Randomized traffic with terminators and occasional reset
      for (int n = 0; n < 4000; n++) begin
         bit          v;
         logic [7:0]  d;
         v = ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 5) == 0) ? 8'hFA : 8'($urandom);
         rst_n = ($urandom_range(0, 599) != 0);
         cyc(v, d, ($urandom_range(0, 2) == 0));
      end
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
